// File: rtl/arm_decode_pipe_if.sv
// Bundle of fetch-side and execute-side signals for arm_decode_pipe.
// No logic here; carries the valid/ready pairs plus the decoded bundle.
// Backpressure travels on in_ready (to fetch) and out_ready (from execute).
interface arm_decode_pipe_if #(
    parameter int PTR_W = 2
);
    // fetch side
    logic             flush;
    logic [3:0]       flags;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    // execute side
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic             cond_pass;
    logic             illegal;
    logic [3:0]       write_rd;
    logic [3:0]       read_rn;
    logic [3:0]       read_rm;
    logic [3:0]       read_rs;
    logic             rd_we;
    logic             cpsr_we;
    logic [3:0]       alu_sel;
    logic             shiftee_sel;
    logic [7:0]       immed_8;
    logic [1:0]       shifter_sel;
    logic [3:0]       rotate_imm;
    logic [4:0]       shift_imm;
    logic [3:0]       barrel_sel;
    logic [PTR_W:0]   count;

    // decoder view
    modport slave (
        input  flush, flags, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, cond_pass, illegal,
               write_rd, read_rn, read_rm, read_rs, rd_we, cpsr_we,
               alu_sel, shiftee_sel, immed_8, shifter_sel, rotate_imm,
               shift_imm, barrel_sel, count
    );

    // fetch/execute view
    modport master (
        output flush, flags, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, cond_pass, illegal,
               write_rd, read_rn, read_rm, read_rs, rd_we, cpsr_we,
               alu_sel, shiftee_sel, immed_8, shifter_sel, rotate_imm,
               shift_imm, barrel_sel, count
    );
endinterface

// File: rtl/arm_decode_pipe.sv
// Buffered ARM data-processing decoder: FIFO of fetched words feeding a registered decode stage.
// Latency: word pushed at edge k is loaded into the output register at edge k+1 (2 edges push->consume).
// Backpressure: in_ready low when FIFO full or flushing; output bundle holds while out_valid & !out_ready.
module arm_decode_pipe #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    arm_decode_pipe_if.slave   bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic        cond_pass;
        logic        illegal;
        logic [3:0]  write_rd;
        logic [3:0]  read_rn;
        logic [3:0]  read_rm;
        logic [3:0]  read_rs;
        logic        rd_we;
        logic        cpsr_we;
        logic [3:0]  alu_sel;
        logic        shiftee_sel;
        logic [7:0]  immed_8;
        logic [1:0]  shifter_sel;
        logic [3:0]  rotate_imm;
        logic [4:0]  shift_imm;
        logic [3:0]  barrel_sel;
    } bundle_t;

    localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

    // FIFO storage and bookkeeping
    logic [31:0]    r_mem_inst [DEPTH];
    logic [31:0]    r_mem_pc   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    // output stage
    logic           r_out_valid;
    bundle_t        r_bundle;

    logic           w_in_ready;
    logic           w_push;
    logic           w_load;
    logic [31:0]    w_inst;
    bundle_t        w_dec;

    // Evaluate an ARM condition code against {N,Z,C,V}.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c & !z;
            4'h9:    r = !c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // in_ready looks only at registered occupancy, so a full FIFO refuses even on a pop cycle.
    assign w_in_ready = (r_count < L_DEPTH) & !bus.flush;
    assign w_push     = bus.in_valid & w_in_ready & !reset;
    // Output register refills from the head whenever it is empty or being consumed.
    assign w_load     = (r_count != '0) & (!r_out_valid | bus.out_ready);
    assign w_inst     = r_mem_inst[r_rd_ptr];

    // Decode the FIFO head; flags are live here and get frozen when the load edge captures them.
    always_comb begin
        w_dec             = '0;
        w_dec.pc          = r_mem_pc[r_rd_ptr];
        w_dec.cond_pass   = cond_eval(w_inst[31:28], bus.flags);
        w_dec.illegal     = (w_inst[27:26] != 2'b00) | (!w_inst[25] & w_inst[7] & w_inst[4]);
        w_dec.write_rd    = w_inst[15:12];
        w_dec.read_rn     = w_inst[19:16];
        w_dec.read_rm     = w_inst[3:0];
        w_dec.read_rs     = w_inst[11:8];
        w_dec.alu_sel     = w_inst[24:21];
        w_dec.shiftee_sel = w_inst[25];
        w_dec.immed_8     = w_inst[7:0];
        w_dec.rotate_imm  = w_inst[11:8];
        w_dec.shift_imm   = w_inst[11:7];
        if (w_inst[25]) begin
            w_dec.shifter_sel = 2'b00;
            w_dec.barrel_sel  = 4'b0011;
        end else if (w_inst[4]) begin
            w_dec.shifter_sel = 2'b10;
            w_dec.barrel_sel  = {2'b01, w_inst[6:5]};
        end else begin
            w_dec.shifter_sel = 2'b01;
            w_dec.barrel_sel  = {2'b00, w_inst[6:5]};
        end
        // compare/test ops (alu_sel 10xx) only update flags, never Rd
        w_dec.rd_we   = w_dec.cond_pass & !w_dec.illegal & (w_inst[24:23] != 2'b10);
        w_dec.cpsr_we = w_dec.cond_pass & !w_dec.illegal & w_inst[20];
    end

    // FIFO payload write; storage itself needs no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= bus.in_inst;
            r_mem_pc[r_wr_ptr]   <= bus.in_pc;
        end
    end

    // FIFO pointers and occupancy; flush wins over any push/pop on the same edge.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_load};
        end
    end

    // Output register: load from head, drop valid when consumed with nothing behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_bundle    <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_bundle    <= w_dec;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.count       = r_count;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_bundle.pc;
    assign bus.cond_pass   = r_bundle.cond_pass;
    assign bus.illegal     = r_bundle.illegal;
    assign bus.write_rd    = r_bundle.write_rd;
    assign bus.read_rn     = r_bundle.read_rn;
    assign bus.read_rm     = r_bundle.read_rm;
    assign bus.read_rs     = r_bundle.read_rs;
    assign bus.rd_we       = r_bundle.rd_we;
    assign bus.cpsr_we     = r_bundle.cpsr_we;
    assign bus.alu_sel     = r_bundle.alu_sel;
    assign bus.shiftee_sel = r_bundle.shiftee_sel;
    assign bus.immed_8     = r_bundle.immed_8;
    assign bus.shifter_sel = r_bundle.shifter_sel;
    assign bus.rotate_imm  = r_bundle.rotate_imm;
    assign bus.shift_imm   = r_bundle.shift_imm;
    assign bus.barrel_sel  = r_bundle.barrel_sel;

endmodule

// File: tb/tb_arm_decode_pipe.sv
// Self-checking bench for arm_decode_pipe: directed cases plus randomized traffic.
// Reference keeps a queue of accepted words and the last loaded bundle, decoded from ARM rules.
// Inputs change at negedge; outputs are sampled 1ns after posedge.
module tb_arm_decode_pipe;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_decode_pipe_if #(.PTR_W(PTR_W)) bus ();

    arm_decode_pipe #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } word_t;

    word_t        m_q[$];
    logic         m_valid  = 1'b0;
    logic [79:0]  m_bundle = '0;
    logic         dut_acc;
    logic [31:0]  seen_pc[$];

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected decoded bundle written straight from the instruction-set rules.
    function automatic logic [79:0] ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                               input logic [3:0] f);
        bit n, z, c, v, pass, imm, regsh, ill, cmp, rdw, cpw;
        logic [1:0] shsel;
        logic [3:0] barrel;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (inst[31:28])
            0: pass = z;        1: pass = !z;
            2: pass = c;        3: pass = !c;
            4: pass = n;        5: pass = !n;
            6: pass = v;        7: pass = !v;
            8: pass = c && !z;  9: pass = !c || z;
            10: pass = (n == v); 11: pass = (n != v);
            12: pass = !z && (n == v);
            13: pass = z || (n != v);
            14: pass = 1;
            default: pass = 0;
        endcase
        imm   = inst[25];
        regsh = !imm && inst[4];
        ill   = (inst[27:26] != 0) || (!imm && inst[7] && inst[4]);
        cmp   = (inst[24:21] >= 8) && (inst[24:21] <= 11);
        rdw   = pass && !ill && !cmp;
        cpw   = pass && !ill && inst[20];
        shsel = imm ? 2'd0 : (regsh ? 2'd2 : 2'd1);
        barrel = imm ? 4'b0011 : {1'b0, regsh, inst[6:5]};
        return {pc, pass, ill, inst[15:12], inst[19:16], inst[3:0], inst[11:8], rdw, cpw,
                inst[24:21], imm, inst[7:0], shsel, inst[11:8], inst[11:7], barrel};
    endfunction

    function automatic logic [79:0] dut_bundle();
        return {bus.out_pc, bus.cond_pass, bus.illegal, bus.write_rd, bus.read_rn, bus.read_rm,
                bus.read_rs, bus.rd_we, bus.cpsr_we, bus.alu_sel, bus.shiftee_sel, bus.immed_8,
                bus.shifter_sel, bus.rotate_imm, bus.shift_imm, bus.barrel_sel};
    endfunction

    // One clock: drive inputs, advance the reference at the edge, compare afterwards.
    task automatic step(input logic rst, input logic fl, input logic iv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic ordy, input logic [3:0] flg);
        bit model_acc, load;
        word_t w;
        @(negedge clk);
        reset         = rst;
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flags     = flg;
        #1;
        model_acc = iv && (m_q.size() < DEPTH) && !fl;
        if (!rst) check("in_ready", bus.in_ready, (m_q.size() < DEPTH) && !fl);
        dut_acc = iv && bus.in_ready && !rst;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_valid  = 1'b0;
            m_bundle = '0;
        end else if (fl) begin
            m_q.delete();
            m_valid = 1'b0;
        end else begin
            load = (m_q.size() > 0) && (!m_valid || ordy);
            if (load) begin
                w = m_q.pop_front();
                m_bundle = ref_decode(w.inst, w.pc, flg);
                m_valid  = 1'b1;
            end else if (ordy) begin
                m_valid = 1'b0;
            end
            if (model_acc) m_q.push_back('{inst: inst, pc: pc});
        end
        #1;
        check("out_valid", bus.out_valid, m_valid);
        check("count", bus.count, m_q.size());
        check("bundle", dut_bundle(), m_bundle);
    endtask

    task automatic idle(input logic ordy, input logic [3:0] flg);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy, flg);
    endtask

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_inst = '0; bus.in_pc = '0;
        bus.out_ready = 1'b0; bus.flags = 4'h0;

        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        check("rst_bundle", dut_bundle(), 80'h0);
        check("rst_count", bus.count, 0);

        // AND R1,R1,#2
        step(1'b0, 1'b0, 1'b1, 32'hE2011002, 32'h100, 1'b1, 4'h0);
        check("and_not_yet", bus.out_valid, 1'b0);
        idle(1'b1, 4'h0);
        check("and_valid", bus.out_valid, 1'b1);
        check("and_alu", bus.alu_sel, 4'h0);
        check("and_rd_rn", {bus.write_rd, bus.read_rn}, 8'h11);
        check("and_imm", {bus.shiftee_sel, bus.immed_8, bus.shifter_sel, bus.barrel_sel}, {1'b1, 8'h02, 2'b00, 4'b0011});
        check("and_we", {bus.rd_we, bus.cpsr_we}, 2'b10);

        // CMP R7,R8
        step(1'b0, 1'b0, 1'b1, 32'hE1570008, 32'h104, 1'b1, 4'h0);
        idle(1'b1, 4'h0);
        check("cmp_fields", {bus.alu_sel, bus.read_rn, bus.read_rm}, 12'hA78);
        check("cmp_we", {bus.rd_we, bus.cpsr_we}, 2'b01);
        check("cmp_shift", {bus.shifter_sel, bus.shift_imm, bus.barrel_sel}, {2'b01, 5'd0, 4'b0000});

        // MOV R12,R4,ROR R3
        step(1'b0, 1'b0, 1'b1, 32'hE1A0C374, 32'h108, 1'b1, 4'h0);
        idle(1'b1, 4'h0);
        check("mov_fields", {bus.alu_sel, bus.write_rd, bus.read_rm, bus.read_rs}, 16'hDC43);
        check("mov_shift", {bus.shifter_sel, bus.barrel_sel}, {2'b10, 4'b0111});

        // EQ with Z clear then Z set
        step(1'b0, 1'b0, 1'b1, 32'h02011002, 32'h10C, 1'b1, 4'h0);
        idle(1'b1, 4'h0);
        check("eq_fail", {bus.out_valid, bus.cond_pass, bus.rd_we}, 3'b100);
        step(1'b0, 1'b0, 1'b1, 32'h02011002, 32'h110, 1'b1, 4'h4);
        idle(1'b1, 4'h4);
        check("eq_pass", {bus.out_valid, bus.cond_pass, bus.rd_we}, 3'b111);
        idle(1'b1, 4'h0);

        // Fill under stall; flags change while held must not disturb the bundle
        begin
            int acc_n = 0;
            for (int i = 0; i < DEPTH + 2; i++) begin
                step(1'b0, 1'b0, 1'b1, 32'hE0800001 | (i << 12), 32'h200 + 4 * i, 1'b0, 4'(i));
                if (dut_acc) acc_n++;
            end
            check("full_acc", acc_n, DEPTH + 1);
            check("full_count", bus.count, DEPTH);
            check("full_pc", bus.out_pc, 32'h200);
        end
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'hF);
            if (bus.out_valid) seen_pc.push_back(bus.out_pc);
        end
        check("drain_n", seen_pc.size(), DEPTH);
        // first (0x200) left before drain began; the rest follow in order across the wrap
        for (int i = 0; i < seen_pc.size(); i++)
            check("drain_order", seen_pc[i], 32'h204 + 4 * i);

        // Flush while full with a word offered
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b0, 1'b0, 1'b1, 32'hE2822001, 32'h300 + 4 * i, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 32'hE2833001, 32'h400, 1'b0, 4'h0);
        check("flush_state", {bus.out_valid, bus.count}, 4'b0);

        // Reset mid-stream
        step(1'b0, 1'b0, 1'b1, 32'hE2844001, 32'h500, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 32'hE2855001, 32'h504, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 32'hE2866001, 32'h508, 1'b0, 4'h0);
        check("rst_mid", {bus.out_valid, bus.count, dut_bundle()}, 84'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] inst;
            inst = $urandom;
            if ($urandom_range(0, 7) != 0) inst[27:26] = 2'b00;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 9) < 7, inst, $urandom,
                 $urandom_range(0, 9) < 6, 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
